mips_mc_ctrl: RTL and testbench

- Multi-cycle control FSM for the 16-bit MIPS datapath.
- Sequences one instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath mux select (ALU operand, RegDst, MemtoReg, PC source) plus the register, PC, IR and memory strobes.
- Handshakes with instruction/data memory via mem_ready, with a bounded wait timeout.

---
 rtl/mips_mc_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control FSM for the 16-bit MIPS datapath: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath mux selects and strobes, and faults on a stalled memory handshake.
module mips_mc_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int OPW         = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic           ir_write,
    output logic           reg_write,
    output logic           mem_read,
    output logic           mem_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic [1:0]     pc_src,
    output logic           busy,
    output logic           halted,
    output logic           fault
);

    localparam logic [OPW-1:0] OP_R    = OPW'(4'h0);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_LW   = OPW'(4'h2);
    localparam logic [OPW-1:0] OP_SW   = OPW'(4'h3);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(4'h4);
    localparam logic [OPW-1:0] OP_J    = OPW'(4'h5);
    localparam logic [OPW-1:0] OP_HALT = OPW'(4'hF);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    state_t          state, state_nxt;
    logic [OPW-1:0]  op_q;
    logic [CW-1:0]   wait_cnt;
    logic            mem_wait;
    logic            timed_out;

    // Cycles spent stalled on memory; the last allowed cycle still accepts mem_ready.
    assign mem_wait  = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    assign timed_out = (MEM_TIMEOUT != 0) && mem_wait && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE)
                op_q <= opcode;
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (mem_wait)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      state_nxt = S_DECODE;
                else if (timed_out) state_nxt = S_FAULT;
            end
            S_DECODE: begin
                case (opcode)
                    OP_HALT:                                   state_nxt = S_HALTED;
                    OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ:       state_nxt = S_EXEC;
                    default:                                   state_nxt = S_FETCH;
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_R, OP_ADDI: state_nxt = S_WB;
                    OP_LW, OP_SW:  state_nxt = S_MEM;
                    default:       state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready)      state_nxt = (op_q == OP_LW) ? S_WB : S_FETCH;
                else if (timed_out) state_nxt = S_FAULT;
            end
            S_WB:     state_nxt = S_FETCH;
            S_HALTED: state_nxt = S_HALTED;
            S_FAULT:  state_nxt = S_FAULT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // DECODE reads the live opcode because op_q is only loaded on leaving it.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 2'b00;
        busy       = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        case (state)
            S_FETCH: begin
                busy      = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                busy      = 1'b1;
                alu_src_b = 2'b11;
                if (opcode == OP_J) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
            end
            S_EXEC: begin
                busy = 1'b1;
                case (op_q)
                    OP_R: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b10;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                    end
                    OP_BEQ: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b01;
                        pc_src    = 2'b01;
                        pc_write  = zero;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                busy      = 1'b1;
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
            end
            S_WB: begin
                busy       = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = (op_q == OP_R);
                mem_to_reg = (op_q == OP_LW);
            end
            S_HALTED: halted = 1'b1;
            S_FAULT:  fault  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: a cycle-by-cycle vector table over every instruction class,
// plus hand sequences for memory timeout, last-cycle ready and asynchronous reset mid-store.
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, reg_write, mem_read, mem_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       reg_dst, mem_to_reg, busy, halted, fault;

    int checks = 0;
    int errors = 0;

    mips_mc_ctrl #(.MEM_TIMEOUT(15), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_src(pc_src),
        .busy(busy), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    // {pc_write, ir_write, reg_write, mem_read, mem_write, a, b[2], op[2], reg_dst, m2r, pc_src[2], busy, halted, fault}
    function automatic logic [16:0] ov(input logic pcw, irw, rw, mr, mw, a, input logic [1:0] b, op,
                                       input logic rd, m2r, input logic [1:0] ps, input logic bsy, h, f);
        return {pcw, irw, rw, mr, mw, a, b, op, rd, m2r, ps, bsy, h, f};
    endfunction

    logic [16:0] act;
    assign act = {pc_write, ir_write, reg_write, mem_read, mem_write, alu_src_a, alu_src_b, alu_op,
                  reg_dst, mem_to_reg, pc_src, busy, halted, fault};

    logic [16:0] E_IDLE, E_F1, E_F0, E_DEC, E_DECJ, E_EXR, E_EXI, E_BZ, E_BN;
    logic [16:0] E_MLW, E_MSW, E_WBR, E_WBI, E_WBL, E_H, E_FLT;

    typedef struct {
        logic        st;
        logic [3:0]  opc;
        logic        z;
        logic        rdy;
        logic [16:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input logic [16:0] exp, input string name);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive inputs just after a rising edge, check at the falling edge, then advance one cycle.
    task automatic step(input logic st, input logic [3:0] opc, input logic z, input logic rdy,
                        input logic [16:0] exp, input string name);
        start = st; opcode = opc; zero = z; mem_ready = rdy;
        @(negedge clk);
        check(exp, name);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic add(input logic st, input logic [3:0] opc, input logic z, input logic rdy,
                       input logic [16:0] exp, input string name);
        vec_t v;
        v.st = st; v.opc = opc; v.z = z; v.rdy = rdy; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        E_IDLE = '0;
        E_F1   = ov(1,1,0,1,0,0,2'b01,2'b00,0,0,2'b00,1,0,0);
        E_F0   = ov(0,0,0,1,0,0,2'b01,2'b00,0,0,2'b00,1,0,0);
        E_DEC  = ov(0,0,0,0,0,0,2'b11,2'b00,0,0,2'b00,1,0,0);
        E_DECJ = ov(1,0,0,0,0,0,2'b11,2'b00,0,0,2'b10,1,0,0);
        E_EXR  = ov(0,0,0,0,0,1,2'b00,2'b10,0,0,2'b00,1,0,0);
        E_EXI  = ov(0,0,0,0,0,1,2'b10,2'b00,0,0,2'b00,1,0,0);
        E_BZ   = ov(1,0,0,0,0,1,2'b00,2'b01,0,0,2'b01,1,0,0);
        E_BN   = ov(0,0,0,0,0,1,2'b00,2'b01,0,0,2'b01,1,0,0);
        E_MLW  = ov(0,0,0,1,0,0,2'b00,2'b00,0,0,2'b00,1,0,0);
        E_MSW  = ov(0,0,0,0,1,0,2'b00,2'b00,0,0,2'b00,1,0,0);
        E_WBR  = ov(0,0,1,0,0,0,2'b00,2'b00,1,0,2'b00,1,0,0);
        E_WBI  = ov(0,0,1,0,0,0,2'b00,2'b00,0,0,2'b00,1,0,0);
        E_WBL  = ov(0,0,1,0,0,0,2'b00,2'b00,0,1,2'b00,1,0,0);
        E_H    = ov(0,0,0,0,0,0,2'b00,2'b00,0,0,2'b00,0,1,0);
        E_FLT  = ov(0,0,0,0,0,0,2'b00,2'b00,0,0,2'b00,0,0,1);

        // Non-DECODE rows carry opcode 6 and zero=1 so EXEC/MEM/WB must rely on op_q only.
        add(0,4'h6,1,1,E_IDLE,"idle");
        add(1,4'h6,1,1,E_IDLE,"idle_start");
        add(0,4'h6,1,1,E_F1,  "r_fetch");
        add(0,4'h0,1,1,E_DEC, "r_decode");
        add(0,4'h6,1,1,E_EXR, "r_exec");
        add(0,4'h6,1,1,E_WBR, "r_wb");
        add(1,4'h6,1,1,E_F1,  "addi_fetch_start_ign");
        add(0,4'h1,1,1,E_DEC, "addi_decode");
        add(0,4'h6,1,1,E_EXI, "addi_exec");
        add(0,4'h6,1,1,E_WBI, "addi_wb");
        add(0,4'h6,1,1,E_F1,  "lw_fetch");
        add(0,4'h2,1,1,E_DEC, "lw_decode");
        add(0,4'h6,1,1,E_EXI, "lw_exec");
        add(0,4'h6,1,0,E_MLW, "lw_mem_wait1");
        add(0,4'h6,1,0,E_MLW, "lw_mem_wait2");
        add(0,4'h6,1,0,E_MLW, "lw_mem_wait3");
        add(0,4'h6,1,1,E_MLW, "lw_mem_done");
        add(0,4'h6,1,1,E_WBL, "lw_wb");
        add(0,4'h6,1,1,E_F1,  "sw_fetch");
        add(0,4'h3,1,1,E_DEC, "sw_decode");
        add(0,4'h6,1,1,E_EXI, "sw_exec");
        add(0,4'h6,1,1,E_MSW, "sw_mem");
        add(0,4'h6,1,1,E_F1,  "beq1_fetch");
        add(0,4'h4,1,1,E_DEC, "beq1_decode");
        add(0,4'h6,1,1,E_BZ,  "beq1_exec_taken");
        add(0,4'h6,1,1,E_F1,  "beq0_fetch");
        add(0,4'h4,1,1,E_DEC, "beq0_decode");
        add(0,4'h6,0,1,E_BN,  "beq0_exec_not_taken");
        add(0,4'h6,1,1,E_F1,  "j_fetch");
        add(0,4'h5,1,1,E_DECJ,"j_decode");
        add(0,4'h6,1,1,E_F1,  "ill_fetch");
        add(0,4'h7,1,1,E_DEC, "ill_decode");
        add(0,4'h6,1,0,E_F0,  "fetch_wait");
        add(0,4'h6,1,1,E_F1,  "halt_fetch");
        add(0,4'hF,1,1,E_DEC, "halt_decode");
        add(1,4'h6,1,1,E_H,   "halted_start_ign");
        add(0,4'h6,1,1,E_H,   "halted_sticky");

        rst_n = 1'b0; start = 1'b0; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        check(E_IDLE, "reset_outputs");
        do_reset();
        foreach (tbl[i]) step(tbl[i].st, tbl[i].opc, tbl[i].z, tbl[i].rdy, tbl[i].exp, tbl[i].name);

        // FETCH timeout: 15 waiting cycles then FAULT, which ignores start.
        do_reset();
        step(1, 4'h0, 0, 0, E_IDLE, "to_idle");
        for (int i = 0; i < 15; i++) step(0, 4'h0, 0, 0, E_F0, $sformatf("to_fetch_wait%0d", i));
        step(1, 4'h0, 0, 1, E_FLT, "to_fault");
        step(1, 4'h0, 0, 1, E_FLT, "to_fault_sticky");

        // Ready on the 15th cycle wins over the timeout.
        do_reset();
        step(1, 4'h0, 0, 0, E_IDLE, "lc_idle");
        for (int i = 0; i < 14; i++) step(0, 4'h0, 0, 0, E_F0, $sformatf("lc_fetch_wait%0d", i));
        step(0, 4'h0, 0, 1, E_F1,  "lc_fetch_ready");
        step(0, 4'h0, 0, 1, E_DEC, "lc_decode_no_fault");

        // Async reset in a stalled SW MEM cycle drops mem_write at once.
        do_reset();
        step(1, 4'h0, 0, 1, E_IDLE, "rs_idle");
        step(0, 4'h0, 0, 1, E_F1,   "rs_fetch");
        step(0, 4'h3, 0, 1, E_DEC,  "rs_decode");
        step(0, 4'h0, 0, 1, E_EXI,  "rs_exec");
        mem_ready = 1'b0;
        @(negedge clk);
        check(E_MSW, "rs_mem_strobe");
        rst_n = 1'b0;
        #1;
        check(E_IDLE, "rs_reset_immediate");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 4'h0, 0, 1, E_IDLE, "rs_idle_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
